// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer. Receives a byte stream with a 16-bit
// word-count header followed by big-endian 32-bit words. Writes those words
// to instruction memory from address 0, and holds the core in reset until
// the whole program has landed.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        StHdrHi,
        StHdrLo,
        StData,
        StWrite,
        StRun,
        StErr
    } state_e;

    // Memory depth in words, held at counter width so N == depth compares cleanly.
    localparam logic [16:0] Depth = 17'(1) << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [15:0]           count_n_q, count_n_d;
    logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           shift_q, shift_d;
    logic [16:0]           written_q, written_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic                  accept;
    logic [15:0]           hdr_n;
    logic [16:0]           written_inc;

    // Handshake and derived values used by the next-state logic.
    always_comb begin
        accept      = in_valid && in_ready;
        hdr_n       = {count_n_q[15:8], in_data};
        written_inc = written_q + 17'd1;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        count_n_d   = count_n_q;
        word_addr_d = word_addr_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        written_d   = written_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StHdrHi: begin
                if (accept) begin
                    count_n_d[15:8] = in_data;
                    state_d         = StHdrLo;
                end
            end

            StHdrLo: begin
                if (accept) begin
                    count_n_d[7:0] = in_data;
                    if (hdr_n == 16'd0) begin
                        state_d = StRun;
                    end else if ({1'b0, hdr_n} > Depth) begin
                        state_d = StErr;
                    end else begin
                        word_addr_d = '0;
                        byte_idx_d  = 2'd0;
                        written_d   = 17'd0;
                        state_d     = StData;
                    end
                end
            end

            StData: begin
                if (accept) begin
                    shift_d    = {shift_q[15:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Fourth byte completes the word; capture the write now so
                    // the strobe cycle drives registered address and data.
                    if (byte_idx_q == 2'd3) begin
                        mem_addr_d  = word_addr_q;
                        mem_wdata_d = {shift_q, in_data};
                        state_d     = StWrite;
                    end
                end
            end

            StWrite: begin
                // Address may wrap after the final write of a full memory; unused then.
                word_addr_d = word_addr_q + ADDR_WIDTH'(1);
                written_d   = written_inc;
                if (written_inc == {1'b0, count_n_q}) begin
                    state_d = StRun;
                end else begin
                    state_d = StData;
                end
            end

            StRun: begin
                if (reload) begin
                    state_d = StHdrHi;
                end
            end

            StErr: begin
                state_d = StErr;
            end

            default: begin
                state_d = StHdrHi;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHdrHi;
            count_n_q   <= 16'd0;
            word_addr_q <= '0;
            byte_idx_q  <= 2'd0;
            shift_q     <= 24'd0;
            written_q   <= 17'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            count_n_q   <= count_n_d;
            word_addr_q <= word_addr_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            written_q   <= written_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Outputs decoded from state only; no path from the stream inputs.
    always_comb begin
        in_ready   = (state_q == StHdrHi) || (state_q == StHdrLo) || (state_q == StData);
        mem_we     = (state_q == StWrite);
        core_rst_n = (state_q == StRun);
        done       = (state_q == StRun);
        error      = (state_q == StErr);
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS core. It receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words into instruction memory from word address 0 and holds the core in reset until the whole program is loaded. It is the write side of the instruction memory; the core's fetch path is the read side.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; depth = 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle when in_valid && in_ready.
- reload  in  1  single-cycle request to re-enter load mode; honoured only in RUN.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  word address of the write.
- mem_wdata  out  32  word to write.
- core_rst_n  out  1  active-low reset to the core; low while loading.
- done  out  1  high in RUN.
- error  out  1  high in ERR.

## Operation
- Stream format:
  - Header: 16-bit word count N, MSB byte first.
  - Body: N words, 4 bytes each, MSB byte first (bits 31:24 first).
- States:
  - HDR_HI: in_ready=1. On accept, latch N[15:8] and go to HDR_LO.
  - HDR_LO: in_ready=1. On accept, latch N[7:0], then:
    - N==0: go to RUN.
    - N > 2^ADDR_WIDTH: go to ERR.
    - Otherwise: clear the word address and byte index, then go to DATA.
  - DATA: in_ready=1. Each accepted byte shifts into the assembly register.
    - Byte index counts 0..3.
    - On the 4th byte, go to WRITE.
  - WRITE: in_ready=0 and mem_we=1 for exactly one cycle.
    - mem_addr = current word address; mem_wdata = assembled word.
    - Then increment the word address and the words-written count.
    - If the count equals N, go to RUN; otherwise return to DATA.
  - RUN:
    - in_ready=0, done=1, core_rst_n=1.
    - reload=1 sends the state to HDR_HI; core_rst_n falls on that same edge.
  - ERR:
    - in_ready=0, error=1, core_rst_n=0.
    - Exit only via rst_n.
- Memory writes:
  - mem_addr and mem_wdata are registered and hold their last value when mem_we=0.
  - Memory contents beyond word N-1 are not touched.
- Width rules:
  - The word counter is 17 bits, so N = 2^ADDR_WIDTH is legal and fills memory exactly.
  - The word address wraps only after the final write, where it is unused.
- Flow control:
  - in_valid may stay high across cycles where in_ready=0; no byte is consumed in those cycles.
  - in_valid low stalls the current state indefinitely with no timeout.
- reload is ignored in every state except RUN.
- Reset mid-load: all state is discarded. Next state is HDR_HI; previously written memory words are not cleared.

## Timing
- Reset values: state HDR_HI, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, done=0, error=0. Internal counters are 0.
- All outputs are registered or decoded from state; no combinational path from in_valid/in_data to any output.
- Write timing: mem_we is high in the cycle after the edge that accepts a word's 4th byte. The next byte can be accepted the cycle after that.
- Sustained throughput: 1 word per 5 cycles with in_valid held high.
- Release timing: core_rst_n and done rise on the edge leaving WRITE after the last word. The core therefore sees its first un-reset edge one cycle after the final mem_we.
- N==0: RUN is entered on the edge that accepts the header low byte.
- Load time: a full load of N words takes 2 + 5N cycles minimum from reset release.

## Test plan
- Load 2 words with in_valid held high. Stream 00 02 | 20 08 00 05 | AC 08 00 04.
  - Required: mem_we pulses at addr 0 with 0x20080005, then at addr 1 with 0xAC080004.
  - core_rst_n=1 and done=1 exactly 12 cycles after the first accept.
- Backpressure: same stream with in_valid toggling 1/0 every cycle, and in_valid high during WRITE.
  - Required: identical writes; no byte lost or duplicated.
- Boundary counts:
  - N=0: RUN immediately; no mem_we ever.
  - N=256 (ADDR_WIDTH=8): last write at addr 0xFF, then RUN.
  - N=257: error=1, core_rst_n stays 0, in_ready=0.
- Reload:
  - In RUN, pulse reload, then send a 1-word program 0x00000000. Required: core_rst_n low for the whole load, write at addr 0, then RUN.
  - reload pulsed mid-DATA: no effect.
- Reset mid-load: assert rst_n=0 after the 2nd body byte.
  - Required: outputs return to their reset values asynchronously.
  - The next stream 00 01 11 22 33 44 writes 0x11223344 at addr 0.
